// File: rtl/input_cond_pkg.sv
// Shared constants and helpers for the board input conditioner.
package input_cond_pkg;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Idle (released / off) levels of the raw inputs
    localparam logic KEY_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

    // Width of a counter able to hold 0..n
    function automatic int cnt_width(int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce counter, clean register and
// registered rise/fall pulses aligned with the clean level change.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("debounce_bit: DEBOUNCE_CYCLES must be >= 1");
    end

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          clean_next;
    logic          rise_next;
    logic          fall_next;

    // Next-state: any agreement clears the count; a full stable run commits s2.
    always_comb begin
        cnt_next   = '0;
        clean_next = clean;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        if (s2 == clean) begin
            cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
            clean_next = s2;
            rise_next  = s2;
            fall_next  = ~s2;
        end else begin
            cnt_next = cnt + 1'b1;
        end
    end

    // State registers with synchronous reset to the idle level.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1    <= RESET_VAL;
            s2    <= RESET_VAL;
            clean <= RESET_VAL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            clean <= clean_next;
            cnt   <= cnt_next;
            rise  <= rise_next;
            fall  <= fall_next;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces DE10-Lite KEY/SW inputs for the SoC PIOs and
// produces single-cycle press/release/change pulses for fabric logic.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int NUM_SW          = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] KEY_raw,
    input  logic [NUM_SW-1:0]   SW_raw,
    output logic [NUM_KEYS-1:0] KEY_clean,
    output logic [NUM_SW-1:0]   SW_clean,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_SW-1:0]   sw_change
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;

    // Buttons are active-low: a press is a falling clean edge.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (KEY_IDLE)
        ) u_key (
            .Clk  (Clk),
            .Reset(Reset),
            .raw  (KEY_raw[i]),
            .clean(KEY_clean[i]),
            .rise (key_release[i]),
            .fall (key_press[i])
        );
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (SW_IDLE)
        ) u_sw (
            .Clk  (Clk),
            .Reset(Reset),
            .raw  (SW_raw[i]),
            .clean(SW_clean[i]),
            .rise (sw_rise[i]),
            .fall (sw_fall[i])
        );
    end

    // rise and fall are each registered and mutually exclusive per bit
    always_comb begin
        sw_change = sw_rise | sw_fall;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4.
module tb_input_conditioner;

    localparam int DC = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] KEY_raw;
    logic [7:0] SW_raw;
    logic [1:0] KEY_clean;
    logic [7:0] SW_clean;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic [7:0] sw_change;

    int n_vec = 0;
    int n_bad = 0;
    int np    = 0;

    input_conditioner #(
        .NUM_KEYS       (2),
        .NUM_SW         (8),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .KEY_raw    (KEY_raw),
        .SW_raw     (SW_raw),
        .KEY_clean  (KEY_clean),
        .SW_clean   (SW_clean),
        .key_press  (key_press),
        .key_release(key_release),
        .sw_change  (sw_change)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] key;
        logic [7:0] sw;
        int         adv;
        logic [1:0] kc;
        logic [7:0] sc;
        logic [1:0] kp;
        logic [1:0] kr;
        logic [7:0] ch;
        int         npulse;
    } vec_t;

    vec_t vecs[12];

    // Advance one edge, sample 1 time unit later and tally pulse bits seen.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
            np += $countones(key_press) + $countones(key_release) + $countones(sw_change);
        end
    endtask

    task automatic check_outs(input string name, input logic [1:0] kc, input logic [7:0] sc,
                              input logic [1:0] kp, input logic [1:0] kr, input logic [7:0] ch);
        logic [21:0] act;
        logic [21:0] exp;
        act = {KEY_clean, SW_clean, key_press, key_release, sw_change};
        exp = {kc, sc, kp, kr, ch};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {kc,sc,kp,kr,ch} got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_np(input string name, input int exp);
        n_vec++;
        if (np != exp) begin
            n_bad++;
            $display("FAIL %s pulse count: got %0d expected %0d", name, np, exp);
        end
    endtask

    initial begin
        // Each vector: drive inputs just after an edge, advance adv edges, compare.
        vecs[0]  = '{"reset",        1'b1, 2'b11, 8'h00, 2,  2'b11, 8'h00, 2'b00, 2'b00, 8'h00, 0};
        vecs[1]  = '{"idle20",       1'b0, 2'b11, 8'h00, 20, 2'b11, 8'h00, 2'b00, 2'b00, 8'h00, 0};
        vecs[2]  = '{"key0_wait",    1'b0, 2'b10, 8'h00, 5,  2'b11, 8'h00, 2'b00, 2'b00, 8'h00, 0};
        vecs[3]  = '{"key0_press",   1'b0, 2'b10, 8'h00, 1,  2'b10, 8'h00, 2'b01, 2'b00, 8'h00, 1};
        vecs[4]  = '{"key0_pdrop",   1'b0, 2'b10, 8'h00, 1,  2'b10, 8'h00, 2'b00, 2'b00, 8'h00, 0};
        vecs[5]  = '{"key0_release", 1'b0, 2'b11, 8'h00, 8,  2'b11, 8'h00, 2'b00, 2'b00, 8'h00, 1};
        vecs[6]  = '{"sw_a5_wait",   1'b0, 2'b11, 8'hA5, 5,  2'b11, 8'h00, 2'b00, 2'b00, 8'h00, 0};
        vecs[7]  = '{"sw_a5_set",    1'b0, 2'b11, 8'hA5, 1,  2'b11, 8'hA5, 2'b00, 2'b00, 8'hA5, 4};
        vecs[8]  = '{"sw_a5_pdrop",  1'b0, 2'b11, 8'hA5, 1,  2'b11, 8'hA5, 2'b00, 2'b00, 8'h00, 0};
        vecs[9]  = '{"sw_00_wait",   1'b0, 2'b11, 8'h00, 5,  2'b11, 8'hA5, 2'b00, 2'b00, 8'h00, 0};
        vecs[10] = '{"sw_00_set",    1'b0, 2'b11, 8'h00, 1,  2'b11, 8'h00, 2'b00, 2'b00, 8'hA5, 4};
        vecs[11] = '{"sw_00_idle",   1'b0, 2'b11, 8'h00, 3,  2'b11, 8'h00, 2'b00, 2'b00, 8'h00, 0};

        Reset   = 1'b1;
        KEY_raw = 2'b11;
        SW_raw  = 8'h00;
        @(posedge Clk);
        #1;

        for (int v = 0; v < 12; v++) begin
            Reset   = vecs[v].rst;
            KEY_raw = vecs[v].key;
            SW_raw  = vecs[v].sw;
            np      = 0;
            tick(vecs[v].adv);
            check_outs(vecs[v].name, vecs[v].kc, vecs[v].sc, vecs[v].kp, vecs[v].kr, vecs[v].ch);
            check_np(vecs[v].name, vecs[v].npulse);
        end

        // KEY[1] bounces 0,1,0,1 every 2 cycles, then settles low.
        np = 0;
        for (int i = 0; i < 4; i++) begin
            KEY_raw[1] = (i % 2 == 1);
            tick(2);
        end
        KEY_raw[1] = 1'b0;
        tick(DC + 1);
        check_outs("bounce_quiet", 2'b11, 8'h00, 2'b00, 2'b00, 8'h00);
        check_np("bounce_quiet", 0);
        np = 0;
        tick(1);
        check_outs("bounce_press", 2'b01, 8'h00, 2'b10, 2'b00, 8'h00);
        check_np("bounce_press", 1);
        KEY_raw = 2'b11;
        tick(DC + 4);

        // Reset lands three edges into a KEY[0] press count.
        np = 0;
        KEY_raw = 2'b10;
        tick(4);
        Reset = 1'b1;
        tick(2);
        check_outs("midreset", 2'b11, 8'h00, 2'b00, 2'b00, 8'h00);
        Reset = 1'b0;
        tick(DC + 1);
        check_outs("postreset_wait", 2'b11, 8'h00, 2'b00, 2'b00, 8'h00);
        check_np("midreset_quiet", 0);
        tick(1);
        check_outs("postreset_press", 2'b10, 8'h00, 2'b01, 2'b00, 8'h00);
        KEY_raw = 2'b11;
        tick(DC + 4);

        // Switch already high while reset is held.
        np = 0;
        Reset  = 1'b1;
        SW_raw = 8'h80;
        tick(2);
        check_outs("sw7_in_reset", 2'b11, 8'h00, 2'b00, 2'b00, 8'h00);
        Reset = 1'b0;
        tick(DC + 1);
        check_outs("sw7_wait", 2'b11, 8'h00, 2'b00, 2'b00, 8'h00);
        tick(1);
        check_outs("sw7_set", 2'b11, 8'h80, 2'b00, 2'b00, 8'h80);
        tick(1);
        check_outs("sw7_pdrop", 2'b11, 8'h80, 2'b00, 2'b00, 8'h00);
        check_np("sw7_once", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
